// File: rtl/algo_mrnw_1p_init_seq_if.sv
// Core-side and T1-side bank bus of the init sequencer front-end.
// master drives the core requests and the physical read data; slave is the sequencer.
interface algo_mrnw_1p_init_seq_if #(
  parameter int NUMVBNK = 1,
  parameter int BITVROW = 13,
  parameter int PHYWDTH = 128
);
  logic [NUMVBNK-1:0]              core_writeA;
  logic [NUMVBNK-1:0][BITVROW-1:0] core_addrA;
  logic [NUMVBNK-1:0][PHYWDTH-1:0] core_dinA;
  logic [NUMVBNK-1:0][PHYWDTH-1:0] core_bwA;
  logic [NUMVBNK-1:0]              core_readB;
  logic [NUMVBNK-1:0][BITVROW-1:0] core_addrB;
  logic [NUMVBNK-1:0][PHYWDTH-1:0] core_doutB;
  logic [NUMVBNK-1:0]              t1_writeA;
  logic [NUMVBNK-1:0][BITVROW-1:0] t1_addrA;
  logic [NUMVBNK-1:0][PHYWDTH-1:0] t1_dinA;
  logic [NUMVBNK-1:0][PHYWDTH-1:0] t1_bwA;
  logic [NUMVBNK-1:0]              t1_readB;
  logic [NUMVBNK-1:0][BITVROW-1:0] t1_addrB;
  logic [NUMVBNK-1:0][PHYWDTH-1:0] t1_doutB;

  modport master (
    output core_writeA, core_addrA, core_dinA, core_bwA, core_readB, core_addrB, t1_doutB,
    input  core_doutB, t1_writeA, t1_addrA, t1_dinA, t1_bwA, t1_readB, t1_addrB
  );
  modport slave (
    input  core_writeA, core_addrA, core_dinA, core_bwA, core_readB, core_addrB, t1_doutB,
    output core_doutB, t1_writeA, t1_addrA, t1_dinA, t1_bwA, t1_readB, t1_addrB
  );
endinterface

// File: rtl/algo_mrnw_1p_init_seq.sv
// Reset-qualified memory init sequencer in front of T1 banks: writes INITVAL to
// every row, then passes core traffic straight through once ready.
module algo_mrnw_1p_init_seq_lane #(
  parameter int                 BITVROW = 13,
  parameter int                 PHYWDTH = 128,
  parameter logic [PHYWDTH-1:0] INITVAL = '0
) (
  input  logic               run_i,
  input  logic               init_we_i,
  input  logic [BITVROW-1:0] init_row_i,
  input  logic               core_write_i,
  input  logic [BITVROW-1:0] core_addrA_i,
  input  logic [PHYWDTH-1:0] core_din_i,
  input  logic [PHYWDTH-1:0] core_bw_i,
  input  logic               core_read_i,
  input  logic [BITVROW-1:0] core_addrB_i,
  output logic               t1_write_o,
  output logic [BITVROW-1:0] t1_addrA_o,
  output logic [PHYWDTH-1:0] t1_din_o,
  output logic [PHYWDTH-1:0] t1_bw_o,
  output logic               t1_read_o,
  output logic [BITVROW-1:0] t1_addrB_o
);
  // Outside RUN only the bank being initialised sees anything non-zero.
  always_comb begin
    t1_write_o = init_we_i;
    t1_addrA_o = init_we_i ? init_row_i : '0;
    t1_din_o   = init_we_i ? INITVAL : '0;
    t1_bw_o    = {PHYWDTH{init_we_i}};
    t1_read_o  = 1'b0;
    t1_addrB_o = '0;
    if (run_i) begin
      t1_write_o = core_write_i;
      t1_addrA_o = core_addrA_i;
      t1_din_o   = core_din_i;
      t1_bw_o    = core_bw_i;
      t1_read_o  = core_read_i;
      t1_addrB_o = core_addrB_i;
    end
  end
endmodule

module algo_mrnw_1p_init_seq #(
  parameter int                 NUMVBNK  = 1,
  parameter int                 BITVBNK  = 1,
  parameter int                 NUMVROW  = 8192,
  parameter int                 BITVROW  = 13,
  parameter int                 PHYWDTH  = 128,
  parameter int                 RSTSTG   = 2,
  parameter logic [PHYWDTH-1:0] INITVAL  = '0,
  parameter int                 INITMODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic init_req_i,
  output logic ready_o,
  output logic init_busy_o,
  output logic ovr_err_o,
  algo_mrnw_1p_init_seq_if.slave bus
);
  typedef enum logic [1:0] {ST_RST, ST_INIT, ST_RUN} state_e;

  localparam logic [BITVROW-1:0] LAST_ROW  = BITVROW'(NUMVROW - 1);
  localparam logic [BITVBNK-1:0] LAST_BANK = BITVBNK'(NUMVBNK - 1);

  logic [RSTSTG-1:0]  rst_sr_q;
  logic [RSTSTG:0]    rst_hist;
  logic               rst_int;
  state_e             state_q, state_d;
  logic [BITVROW-1:0] row_q, row_d;
  logic [BITVBNK-1:0] bank_q, bank_d;
  logic [NUMVBNK-1:0] init_we_q, init_we_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               ovr_q, ovr_d;

  // Reset only counts once rst has been high for RSTSTG+1 consecutive samples.
  assign rst_hist = {rst_sr_q, rst};
  assign rst_int  = &rst_hist;

  always_ff @(posedge clk) rst_sr_q <= rst_hist[RSTSTG-1:0];

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    bank_d  = bank_q;
    ovr_d   = ovr_q;
    case (state_q)
      ST_RST: begin
        state_d = ST_INIT;
        row_d   = '0;
        bank_d  = '0;
        ovr_d   = 1'b0;
      end
      ST_INIT: begin
        if (|bus.core_writeA || |bus.core_readB) ovr_d = 1'b1;
        row_d = row_q + BITVROW'(1);
        if (row_q == LAST_ROW) begin
          row_d = '0;
          if (INITMODE == 0 || bank_q == LAST_BANK) begin
            state_d = ST_RUN;
            bank_d  = '0;
          end else begin
            bank_d = bank_q + BITVBNK'(1);
          end
        end
      end
      ST_RUN: begin
        if (init_req_i) begin
          state_d = ST_INIT;
          row_d   = '0;
          bank_d  = '0;
        end
      end
      default: state_d = ST_RST;
    endcase
    ready_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_INIT);
    for (int b = 0; b < NUMVBNK; b++)
      init_we_d[b] = busy_d && (INITMODE == 0 || bank_d == BITVBNK'(b));
  end

  always_ff @(posedge clk) begin
    if (rst_int) begin
      state_q   <= ST_RST;
      row_q     <= '0;
      bank_q    <= '0;
      init_we_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      bank_q    <= bank_d;
      init_we_q <= init_we_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end

  assign ready_o        = ready_q;
  assign init_busy_o    = busy_q;
  assign ovr_err_o      = ovr_q;
  assign bus.core_doutB = bus.t1_doutB;

  for (genvar b = 0; b < NUMVBNK; b++) begin : g_lane
    algo_mrnw_1p_init_seq_lane #(
      .BITVROW(BITVROW), .PHYWDTH(PHYWDTH), .INITVAL(INITVAL)
    ) u_lane (
      .run_i       (ready_q),
      .init_we_i   (init_we_q[b]),
      .init_row_i  (row_q),
      .core_write_i(bus.core_writeA[b]),
      .core_addrA_i(bus.core_addrA[b]),
      .core_din_i  (bus.core_dinA[b]),
      .core_bw_i   (bus.core_bwA[b]),
      .core_read_i (bus.core_readB[b]),
      .core_addrB_i(bus.core_addrB[b]),
      .t1_write_o  (bus.t1_writeA[b]),
      .t1_addrA_o  (bus.t1_addrA[b]),
      .t1_din_o    (bus.t1_dinA[b]),
      .t1_bw_o     (bus.t1_bwA[b]),
      .t1_read_o   (bus.t1_readB[b]),
      .t1_addrB_o  (bus.t1_addrB[b])
    );
  end
endmodule

// File: tb/tb_algo_mrnw_1p_init_seq.sv
// Bench for the init sequencer: a parallel-init and a serial-init instance share one
// stimulus stream and are checked every cycle against a counting reference model.
module tb_algo_mrnw_1p_init_seq;
  localparam int NB = 2, NR = 16, BR = 4, W = 16, RS = 2;
  localparam logic [W-1:0] IV0 = 16'h0000, IV1 = 16'h3C5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_req = 1'b0;
  always #5 clk = ~clk;

  logic [NB-1:0]         c_wr = '0, c_rd = '0;
  logic [NB-1:0][BR-1:0] c_aA = '0, c_aB = '0;
  logic [NB-1:0][W-1:0]  c_din = '0, c_bw = '0;
  logic [1:0]            rdy, busy, ovr;
  logic [1:0][NB-1:0]         t_wr, t_rd;
  logic [1:0][NB-1:0][BR-1:0] t_aA, t_aB;
  logic [1:0][NB-1:0][W-1:0]  t_din, t_bw, t_do, c_do;
  logic [W-1:0] env [2][NB][NR];

  algo_mrnw_1p_init_seq_if #(.NUMVBNK(NB), .BITVROW(BR), .PHYWDTH(W)) bus0 ();
  algo_mrnw_1p_init_seq_if #(.NUMVBNK(NB), .BITVROW(BR), .PHYWDTH(W)) bus1 ();

  algo_mrnw_1p_init_seq #(.NUMVBNK(NB), .BITVBNK(1), .NUMVROW(NR), .BITVROW(BR), .PHYWDTH(W),
    .RSTSTG(RS), .INITVAL(IV0), .INITMODE(0)) dut0 (
    .clk(clk), .rst(rst), .init_req_i(init_req), .ready_o(rdy[0]), .init_busy_o(busy[0]),
    .ovr_err_o(ovr[0]), .bus(bus0.slave));
  algo_mrnw_1p_init_seq #(.NUMVBNK(NB), .BITVBNK(1), .NUMVROW(NR), .BITVROW(BR), .PHYWDTH(W),
    .RSTSTG(RS), .INITVAL(IV1), .INITMODE(1)) dut1 (
    .clk(clk), .rst(rst), .init_req_i(init_req), .ready_o(rdy[1]), .init_busy_o(busy[1]),
    .ovr_err_o(ovr[1]), .bus(bus1.slave));

  assign bus0.core_writeA = c_wr;  assign bus1.core_writeA = c_wr;
  assign bus0.core_addrA  = c_aA;  assign bus1.core_addrA  = c_aA;
  assign bus0.core_dinA   = c_din; assign bus1.core_dinA   = c_din;
  assign bus0.core_bwA    = c_bw;  assign bus1.core_bwA    = c_bw;
  assign bus0.core_readB  = c_rd;  assign bus1.core_readB  = c_rd;
  assign bus0.core_addrB  = c_aB;  assign bus1.core_addrB  = c_aB;
  assign bus0.t1_doutB    = t_do[0]; assign bus1.t1_doutB  = t_do[1];
  assign t_wr[0]  = bus0.t1_writeA; assign t_wr[1]  = bus1.t1_writeA;
  assign t_aA[0]  = bus0.t1_addrA;  assign t_aA[1]  = bus1.t1_addrA;
  assign t_din[0] = bus0.t1_dinA;   assign t_din[1] = bus1.t1_dinA;
  assign t_bw[0]  = bus0.t1_bwA;    assign t_bw[1]  = bus1.t1_bwA;
  assign t_rd[0]  = bus0.t1_readB;  assign t_rd[1]  = bus1.t1_readB;
  assign t_aB[0]  = bus0.t1_addrB;  assign t_aB[1]  = bus1.t1_addrB;
  assign c_do[0]  = bus0.core_doutB; assign c_do[1] = bus1.core_doutB;

  // Physical bank memories behind each instance (asynchronous read).
  always_comb begin
    t_do = '0;
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < NB; b++) t_do[d][b] = env[d][b][t_aB[d][b]];
  end
  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < NB; b++)
        if (t_wr[d][b])
          env[d][b][t_aA[d][b]] <= (env[d][b][t_aA[d][b]] & ~t_bw[d][b]) | (t_din[d][b] & t_bw[d][b]);

  // Reference model: phase 0 reset, 1 init, 2 run; k counts init writes done so far.
  int m_st [2] = '{0, 0};
  int m_k  [2] = '{0, 0};
  bit m_ovr[2] = '{0, 0};
  logic [RS-1:0] m_hist = '0;
  logic [W-1:0] ref_mem [2][NB][NR];
  int n_cmp = 0, n_bad = 0;

  function automatic int total(input int d);
    return (d == 0) ? NR : NB * NR;
  endfunction
  function automatic logic [W-1:0] iv(input int d);
    return (d == 0) ? IV0 : IV1;
  endfunction

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic check();
    logic [NB-1:0] e_wr, e_rd;
    logic [NB-1:0][BR-1:0] e_aA, e_aB;
    logic [NB-1:0][W-1:0] e_din, e_bw, e_do;
    for (int d = 0; d < 2; d++) begin
      e_wr = '0; e_rd = '0; e_aA = '0; e_aB = '0; e_din = '0; e_bw = '0;
      if (m_st[d] == 1) begin
        for (int b = 0; b < NB; b++)
          if (d == 0 || b == m_k[d] / NR) begin
            e_wr[b] = 1'b1; e_aA[b] = BR'(m_k[d] % NR); e_din[b] = iv(d); e_bw[b] = '1;
          end
      end else if (m_st[d] == 2) begin
        e_wr = c_wr; e_rd = c_rd; e_aA = c_aA; e_aB = c_aB; e_din = c_din; e_bw = c_bw;
      end
      for (int b = 0; b < NB; b++)
        e_do[b] = (m_st[d] == 2 && c_rd[b]) ? ref_mem[d][b][c_aB[b]] : t_do[d][b];
      chk("ready",  d, 64'(rdy[d]),  64'(m_st[d] == 2));
      chk("busy",   d, 64'(busy[d]), 64'(m_st[d] == 1));
      chk("ovr",    d, 64'(ovr[d]),  64'(m_ovr[d]));
      chk("wrA",    d, 64'(t_wr[d]), 64'(e_wr));
      chk("addrA",  d, 64'(t_aA[d]), 64'(e_aA));
      chk("dinA",   d, 64'(t_din[d]), 64'(e_din));
      chk("bwA",    d, 64'(t_bw[d]), 64'(e_bw));
      chk("rdB",    d, 64'(t_rd[d]), 64'(e_rd));
      chk("addrB",  d, 64'(t_aB[d]), 64'(e_aB));
      chk("doutB",  d, 64'(c_do[d]), 64'(e_do));
    end
  endtask

  task automatic model_step();
    logic rint;
    rint = rst && (&m_hist);
    m_hist = {m_hist[RS-2:0], rst};
    for (int d = 0; d < 2; d++) begin
      if (rint) begin
        m_st[d] = 0; m_k[d] = 0; m_ovr[d] = 1'b0;
      end else if (m_st[d] == 0) begin
        m_st[d] = 1; m_k[d] = 0;
      end else if (m_st[d] == 1) begin
        if (|c_wr || |c_rd) m_ovr[d] = 1'b1;
        for (int b = 0; b < NB; b++)
          if (d == 0 || b == m_k[d] / NR) ref_mem[d][b][m_k[d] % NR] = iv(d);
        m_k[d]++;
        if (m_k[d] == total(d)) m_st[d] = 2;
      end else begin
        for (int b = 0; b < NB; b++)
          if (c_wr[b])
            ref_mem[d][b][c_aA[b]] = (ref_mem[d][b][c_aA[b]] & ~c_bw[b]) | (c_din[b] & c_bw[b]);
        if (init_req) begin m_st[d] = 1; m_k[d] = 0; end
      end
    end
  endtask

  task automatic tick(input bit en);
    @(negedge clk);
    if (en) check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rnd_core(input logic [NB-1:0] wr, input logic [NB-1:0] rd);
    c_wr = wr; c_rd = rd;
    for (int b = 0; b < NB; b++) begin
      c_aA[b] = BR'($urandom_range(NR - 1));
      c_aB[b] = BR'($urandom_range(NR - 1));
      c_din[b] = W'($urandom());
      c_bw[b]  = W'($urandom());
    end
  endtask

  initial begin
    rnd_core('0, '0);
    repeat (3) tick(1'b0);
    tick(1'b1);
    rst = 1'b0;
    // Strobes in the release cycle (still RST) must not raise the overrun flag.
    for (int i = 0; i < 36; i++) begin
      rnd_core((i == 0) ? 2'b11 : 2'b00, (i == 0) ? 2'b11 : 2'b00);
      tick(1'b1);
    end
    repeat (24) begin
      rnd_core(NB'($urandom()), NB'($urandom()));
      tick(1'b1);
    end
    rnd_core(2'b11, 2'b00);
    c_aA = {4'd7, 4'd7}; c_din = {16'h00A5, 16'h00A5}; c_bw = '1;
    tick(1'b1);
    rnd_core(2'b00, 2'b11);
    c_aB = {4'd7, 4'd7};
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("row7_rd_b0", d, 64'(c_do[d][0]), 64'h00A5);
      chk("row7_rd_b1", d, 64'(c_do[d][1]), 64'h00A5);
    end
    tick(1'b1);
    // Short reset pulse is filtered out.
    rnd_core('0, '0);
    rst = 1'b1; tick(1'b1); tick(1'b1);
    rst = 1'b0;
    repeat (3) tick(1'b1);
    for (int d = 0; d < 2; d++) chk("glitch_ready", d, 64'(rdy[d]), 64'd1);
    // Three-cycle pulse resets; access in INIT cycle 5 is dropped and flagged.
    rst = 1'b1; repeat (3) tick(1'b1);
    rst = 1'b0;
    for (int i = 0; i < 36; i++) begin
      rnd_core((i == 5) ? 2'b01 : 2'b00, 2'b00);
      tick(1'b1);
    end
    for (int d = 0; d < 2; d++) chk("ovr_held_run", d, 64'(ovr[d]), 64'd1);
    repeat (4) begin
      rnd_core(NB'($urandom()), NB'($urandom()));
      tick(1'b1);
    end
    // Re-init request, plus a second one mid-init that must be ignored.
    rnd_core('0, '0);
    init_req = 1'b1; tick(1'b1);
    init_req = 1'b0;
    for (int i = 0; i < 36; i++) begin
      init_req = (i == 4);
      tick(1'b1);
    end
    init_req = 1'b0;
    repeat (6) begin
      rnd_core(NB'($urandom()), NB'($urandom()));
      tick(1'b1);
    end
    rnd_core('0, '0);
    rst = 1'b1; repeat (3) tick(1'b1);
    rst = 1'b0;
    repeat (3) tick(1'b1);
    for (int d = 0; d < 2; d++) chk("ovr_cleared", d, 64'(ovr[d]), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/algo_mrnw_1p_init_seq.md
Name: algo_mrnw_1p_init_seq

Overview:
- Parametrised front-end between a multi-port algorithmic core and its T1 physical banks.
- Filters reset through a configurable qualification chain, then runs a memory-initialisation sequencer that writes INITVAL to every row of every bank.
- Raises ready when initialisation completes, and then passes core T1 traffic straight through.
- Adds bank-serial or bank-parallel init, software re-init, and a sticky overrun error for core accesses made while not ready.

Parameters:
NUMVBNK 1 number of T1 banks
BITVBNK 1 width of bank index (>= clog2(NUMVBNK), min 1)
NUMVROW 8192 rows per bank
BITVROW 13 row address width
PHYWDTH 128 physical word width
RSTSTG 2 reset qualification stages (>=1)
INITVAL 0 init data, PHYWDTH bits
INITMODE 0 0 = all banks written in parallel, 1 = banks written one at a time

Ports:
clk input 1 clock
rst input 1 synchronous active-high reset
ready output 1 init complete, core traffic accepted
init_busy output 1 sequencer writing
init_req input 1 single-cycle pulse, re-initialise memory
ovr_err output 1 sticky: core access attempted while ready=0
core_writeA input NUMVBNK core write strobe per bank
core_addrA input NUMVBNK*BITVROW core write row
core_dinA input NUMVBNK*PHYWDTH core write data
core_bwA input NUMVBNK*PHYWDTH core bit enables
core_readB input NUMVBNK core read strobe
core_addrB input NUMVBNK*BITVROW core read row
core_doutB output NUMVBNK*PHYWDTH read data to core
t1_writeA output NUMVBNK physical write strobe
t1_addrA output NUMVBNK*BITVROW physical write row
t1_dinA output NUMVBNK*PHYWDTH physical write data
t1_bwA output NUMVBNK*PHYWDTH physical bit enables
t1_readB output NUMVBNK physical read strobe
t1_addrB output NUMVBNK*BITVROW physical read row
t1_doutB input NUMVBNK*PHYWDTH physical read data

Behaviour:
- Reset qualification
  - The rst shift register samples rst every cycle.
  - rst_int = rst AND all RSTSTG stages are high.
  - Reset pulses shorter than RSTSTG+1 cycles are ignored.
- FSM states: RST, INIT, RUN. rst_int forces RST from any state, including mid-INIT.
- RST state
  - ready=0, init_busy=0, ovr_err=0.
  - All t1 strobes, addresses, din and bw are 0. core_doutB = t1_doutB.
  - Row/bank counters are cleared.
- RST -> INIT: on the first cycle with rst_int=0.
- INIT state
  - init_busy=1, ready=0. Core strobes are blocked from t1.
  - Row counter starts at 0 and increments every cycle.
- INITMODE=0 (parallel)
  - Every cycle: t1_writeA all ones, every bank's addrA = row, dinA = INITVAL per bank, bwA all ones.
  - Runs for exactly NUMVROW cycles, row 0..NUMVROW-1.
- INITMODE=1 (serial)
  - Only bank[bank_cnt] is written; other writeA bits are 0.
  - Row wraps NUMVROW-1 -> 0 and increments bank_cnt.
  - Runs for exactly NUMVBNK*NUMVROW cycles.
- t1_readB=0 throughout INIT. t1_addrB = 0.
- INIT -> RUN: the cycle after the last row of the last bank is written.
- ready=1 and init_busy=0 are both registered and assert together on the first RUN cycle.
- RUN state
  - All core_* signals pass combinationally to t1_* (zero added latency).
  - core_doutB = t1_doutB.
- init_req
  - In RUN: next cycle enters INIT (counters reset, ready=0), and the re-init follows the same sequence.
  - In RST or INIT: ignored.
  - Coinciding with rst_int: rst_int wins.
- Overrun
  - Any core_writeA or core_readB bit high while ready=0 and state != RST sets ovr_err on the next cycle.
  - ovr_err clears only in RST.
  - The access is dropped, never queued.
- All outputs are registered except the RUN passthrough and core_doutB.

Test Plan:
- NUMVBNK=2, NUMVROW=16, INITMODE=0, RSTSTG=2; rst high 4 cycles then low -> INIT for 16 cycles, both writeA bits high, addrA 0..15, dinA=0; ready=1 on cycle 17 after rst release.
- Same configuration with INITMODE=1 -> bank0 rows 0..15, then bank1 rows 0..15; only one writeA bit high per cycle; ready after 32 cycles.
- rst pulse of 2 cycles with RSTSTG=2 while in RUN -> ignored, ready stays 1. A 3-cycle pulse -> RST, ready=0.
- core_writeA=2'b01 in INIT cycle 5 -> t1_writeA unaffected, ovr_err=1 next cycle and held through RUN until next reset.
- In RUN, core write row 7 data 0xA5, then core read row 7 with t1 model returning 0xA5 -> t1 signals mirror core in the same cycle, core_doutB=0xA5.
- init_req pulse in RUN -> ready=0 next cycle, full 16-cycle init, ready=1 again; a second init_req issued mid-INIT is ignored (still 16 cycles).
